// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: debouncer sample strobe, run/adjust tick
// prescaler and the IDLE/RUN/ADJUST/CLEAR mode FSM.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | counters frozen, tick prescaler holds its sub-tick phase
//   RUN    | count_en at TICK_HZ
//   ADJUST | count_en at 2*TICK_HZ into the field chosen by sel
//   CLR    | one-cycle clear strobe to the counters

module stopwatch_ctrl #(
    parameter int CLK_HZ    = 100000000,
    parameter int SAMPLE_HZ = 100,
    parameter int TICK_HZ   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       adj,
    input  logic       sel,
    output logic       sample_en,
    output logic       count_en,
    output logic       clear,
    output logic       adj_sec,
    output logic       adj_min,
    output logic [1:0] state
);

    localparam int SAMPLE_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int RUN_DIV    = CLK_HZ / TICK_HZ;
    localparam int ADJ_DIV    = CLK_HZ / (2 * TICK_HZ);
    localparam int SW         = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int TW         = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
    localparam logic [TW-1:0] RUN_LAST    = TW'(RUN_DIV - 1);
    localparam logic [TW-1:0] ADJ_LAST    = TW'(ADJ_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        ADJUST = 2'b10,
        CLR    = 2'b11
    } state_t;

    state_t          cur;
    state_t          nxt;
    logic [SW-1:0]   scnt;
    logic [TW-1:0]   tcnt;

    assign state = cur;

    // Priority: clear_p, then adj, then pause_p.
    always_comb begin
        nxt = cur;
        if (clear_p) begin
            nxt = CLR;
        end else begin
            case (cur)
                IDLE:    nxt = adj ? ADJUST : (pause_p ? RUN : IDLE);
                RUN:     nxt = adj ? ADJUST : (pause_p ? IDLE : RUN);
                ADJUST:  nxt = adj ? ADJUST : IDLE;
                default: nxt = adj ? ADJUST : IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur     <= IDLE;
            clear   <= 1'b0;
            adj_sec <= 1'b0;
            adj_min <= 1'b0;
        end else begin
            cur     <= nxt;
            clear   <= (nxt == CLR);
            adj_sec <= (nxt == ADJUST) & sel;
            adj_min <= (nxt == ADJUST) & ~sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt      <= '0;
            sample_en <= 1'b0;
        end else if (scnt == SAMPLE_LAST) begin
            scnt      <= '0;
            sample_en <= 1'b1;
        end else begin
            scnt      <= scnt + SW'(1);
            sample_en <= 1'b0;
        end
    end

    // Wrap decision uses the pre-edge state; a fresh ADJUST entry restarts the phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt     <= '0;
            count_en <= 1'b0;
        end else begin
            count_en <= 1'b0;
            case (cur)
                RUN: begin
                    if (tcnt >= RUN_LAST) begin
                        tcnt     <= '0;
                        count_en <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ADJUST: begin
                    if (tcnt >= ADJ_LAST) begin
                        tcnt     <= '0;
                        count_en <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                CLR:     tcnt <= '0;
                default: tcnt <= tcnt;
            endcase
            if (nxt == ADJUST && cur != ADJUST) begin
                tcnt <= '0;
            end
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_HZ, default 100, debouncer sampling strobe rate in Hz.
REQ-003 SHALL have parameter TICK_HZ, default 1, run-mode count rate in Hz; adjust-mode rate is 2*TICK_HZ.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pause_p  input  1  one-cycle rising-edge pulse from the pause-button debouncer.
REQ-007 SHALL have port clear_p  input  1  one-cycle rising-edge pulse from the clear-button debouncer.
REQ-008 SHALL have port adj  input  1  debounced level, 1 = adjust mode requested.
REQ-009 SHALL have port sel  input  1  debounced level, 1 = adjust seconds, 0 = adjust minutes.
REQ-010 SHALL have port sample_en  output  1  one-cycle strobe at SAMPLE_HZ, used by all debouncers.
REQ-011 SHALL have port count_en  output  1  one-cycle increment strobe to the stopwatch counters.
REQ-012 SHALL have port clear  output  1  one-cycle clear strobe to the stopwatch counters.
REQ-013 SHALL have port adj_sec  output  1  seconds field is the adjust target.
REQ-014 SHALL have port adj_min  output  1  minutes field is the adjust target.
REQ-015 SHALL have port state  output  2  current state: 00 IDLE, 01 RUN, 10 ADJUST, 11 CLEAR.

Function
REQ-016 SHALL require CLK_HZ divisible by SAMPLE_HZ and by 2*TICK_HZ; prescaler widths SHALL be $clog2 of the respective divide ratio, minimum 1.
REQ-017 SHALL free-run the sample prescaler 0..CLK_HZ/SAMPLE_HZ-1 in every state, with sample_en registered high for one cycle per wrap to 0.
REQ-018 SHALL implement the four-state FSM with transition priority, evaluated at each clk edge: clear_p, then adj, then pause_p.
REQ-019 SHALL transition to CLEAR from any state on clear_p=1, regardless of other inputs.
REQ-020 SHALL remain in CLEAR for exactly one cycle, then go to ADJUST if adj=1, else IDLE.
REQ-021 SHALL transition from IDLE or RUN to ADJUST on adj=1, and from ADJUST to IDLE on adj=0.
REQ-022 SHALL toggle between IDLE and RUN on pause_p=1 with adj=0, and SHALL ignore pause_p in ADJUST and CLEAR.
REQ-023 SHALL assert the registered clear output for exactly the one cycle the FSM is in CLEAR.
REQ-024 SHALL advance the tick prescaler only in RUN (wrap at CLK_HZ/TICK_HZ-1) and in ADJUST (wrap at CLK_HZ/(2*TICK_HZ)-1), pulsing count_en high for one cycle per wrap.
REQ-025 SHALL hold the tick prescaler value in IDLE, so pause and resume preserve sub-tick progress.
REQ-026 SHALL zero the tick prescaler in CLEAR and on every entry to ADJUST.
REQ-027 SHALL evaluate the wrap using the state before the edge: a wrap coincident with pause_p still produces its count_en.
REQ-028 SHALL keep count_en low in IDLE and CLEAR.
REQ-029 SHALL drive adj_sec = (state==ADJUST)&sel and adj_min = (state==ADJUST)&~sel, both registered, with a sel change reflected one cycle later.

Reset
REQ-030 SHALL, while rst_n=0, immediately force state=IDLE, both prescalers=0, and sample_en, count_en, clear, adj_sec, adj_min=0.
REQ-031 SHALL resume from IDLE on the first clk edge after rst_n deasserts, discarding any operation in progress.

Verification (CLK_HZ=20, SAMPLE_HZ=5, TICK_HZ=2)
REQ-032 SHALL verify free run: after reset release, sample_en pulses every 4 cycles, and count_en stays 0 with no pause_p.
REQ-033 SHALL verify run: one pause_p -> state=01, count_en pulses every 10 cycles; a second pause_p after 6 cycles -> state=00, no count_en; a third pause_p -> first count_en 4 cycles after resuming.
REQ-034 SHALL verify clear priority: clear_p and pause_p in the same cycle during RUN -> state=11 for 1 cycle with clear=1, then state=00 and the prescaler restarts from 0.
REQ-035 SHALL verify adjust: adj=1, sel=1 -> state=10, adj_sec=1, count_en every 5 cycles; sel=0 -> adj_min=1 one cycle later; pause_p is ignored; adj=0 -> state=00.
REQ-036 SHALL verify reset mid-run: rst_n low for 3 cycles during RUN -> all outputs 0 asynchronously, state=00 after release, and no count_en until a new pause_p.
